// File: rtl/sym_ld_pkg.sv
// rtl/sym_ld_pkg.sv - shared sizes and FSM state type for the symmetric 4x4 matrix load controller
package sym_ld_pkg;

  localparam int N_DIAG     = 4;
  localparam int N_OFFD     = 6;
  localparam int DATA_W_DEF = 16;
  localparam int SEL1_W     = 2;
  localparam int SEL2_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_e;

endpackage

// File: rtl/ld_chan.sv
// rtl/ld_chan.sv - one element channel: slot counter, ready, registered sel/data/write strobe
module ld_chan #(
  parameter int N_SLOTS = 4,
  parameter int SEL_W   = 2,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_active,
  input  logic              i_drop,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic [SEL_W-1:0]  o_sel,
  output logic [DATA_W-1:0] o_data,
  output logic              o_wr_en,
  output logic              o_full_next
);

  localparam int CNT_W = $clog2(N_SLOTS + 1);
  localparam logic [CNT_W-1:0] LP_FULL = CNT_W'(N_SLOTS);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(N_SLOTS - 1);

  logic [CNT_W-1:0]  r_cnt;
  logic [SEL_W-1:0]  r_sel;
  logic [DATA_W-1:0] r_data;
  logic              r_wr_en;
  logic              w_accept;

  assign o_ready  = i_active && (r_cnt < LP_FULL);
  // A dropped handshake (abort) neither writes nor advances the slot count.
  assign w_accept = i_valid && o_ready && !i_drop;
  // Channel will hold all its slots after this edge; lets the FSM complete without waiting a cycle.
  assign o_full_next = (r_cnt == LP_FULL) || (w_accept && (r_cnt == LP_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_sel   <= '0;
      r_data  <= '0;
      r_wr_en <= 1'b0;
    end else begin
      r_wr_en <= w_accept;
      if (i_clear) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_accept) begin
        r_sel  <= r_cnt[SEL_W-1:0];
        r_data <= i_data;
      end
    end
  end

  assign o_sel   = r_sel;
  assign o_data  = r_data;
  assign o_wr_en = r_wr_en;

endmodule

// File: rtl/sym_matrix_load_ctrl.sv
// rtl/sym_matrix_load_ctrl.sv - loads 4 diagonal and 6 off-diagonal elements of a symmetric 4x4 matrix
module sym_matrix_load_ctrl
  import sym_ld_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              diag_valid,
  input  logic [DATA_W-1:0] diag_data,
  output logic              diag_ready,
  input  logic              offd_valid,
  input  logic [DATA_W-1:0] offd_data,
  output logic              offd_ready,
  output logic [SEL1_W-1:0] sel1,
  output logic [SEL2_W-1:0] sel2,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic              wr_en1,
  output logic              wr_en2,
  output logic              busy,
  output logic              matrix_valid,
  output logic              load_done,
  input  logic              consume
);

  state_e r_state;
  logic   r_busy;
  logic   r_matrix_valid;
  logic   r_load_done;

  logic   w_active;
  logic   w_abort;
  logic   w_clear;
  logic   w_diag_full;
  logic   w_offd_full;

  assign w_active = (r_state == ST_LOAD);
  assign w_abort  = w_active && abort;
  assign w_clear  = ((r_state == ST_IDLE) && start) || w_abort;

  ld_chan #(
    .N_SLOTS (N_DIAG),
    .SEL_W   (SEL1_W),
    .DATA_W  (DATA_W)
  ) u_diag (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_clear),
    .i_active    (w_active),
    .i_drop      (w_abort),
    .i_valid     (diag_valid),
    .i_data      (diag_data),
    .o_ready     (diag_ready),
    .o_sel       (sel1),
    .o_data      (data_out1),
    .o_wr_en     (wr_en1),
    .o_full_next (w_diag_full)
  );

  ld_chan #(
    .N_SLOTS (N_OFFD),
    .SEL_W   (SEL2_W),
    .DATA_W  (DATA_W)
  ) u_offd (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_clear),
    .i_active    (w_active),
    .i_drop      (w_abort),
    .i_valid     (offd_valid),
    .i_data      (offd_data),
    .o_ready     (offd_ready),
    .o_sel       (sel2),
    .o_data      (data_out2),
    .o_wr_en     (wr_en2),
    .o_full_next (w_offd_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_busy         <= 1'b0;
      r_matrix_valid <= 1'b0;
      r_load_done    <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_LOAD;
            r_busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          // Abort wins even when the last elements arrive in the same cycle.
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_diag_full && w_offd_full) begin
            r_state        <= ST_FULL;
            r_busy         <= 1'b0;
            r_matrix_valid <= 1'b1;
            r_load_done    <= 1'b1;
          end
        end
        ST_FULL: begin
          if (consume) begin
            r_state        <= ST_IDLE;
            r_matrix_valid <= 1'b0;
          end
        end
        default: begin
          r_state        <= ST_IDLE;
          r_busy         <= 1'b0;
          r_matrix_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign matrix_valid = r_matrix_valid;
  assign load_done    = r_load_done;

endmodule

// File: tb/tb_sym_matrix_load_ctrl.sv
// tb/tb_sym_matrix_load_ctrl.sv - randomized and directed bench for sym_matrix_load_ctrl
module tb_sym_matrix_load_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        consume = 1'b0;
  logic        diag_valid = 1'b0;
  logic        offd_valid = 1'b0;
  logic [15:0] diag_data = '0;
  logic [15:0] offd_data = '0;
  logic        diag_ready, offd_ready;
  logic [1:0]  sel1;
  logic [2:0]  sel2;
  logic [15:0] data_out1, data_out2;
  logic        wr_en1, wr_en2, busy, matrix_valid, load_done;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what has been loaded so far, expressed as element counts.
  int          m_state;
  int          m_dc, m_oc;
  logic [1:0]  e_sel1;
  logic [2:0]  e_sel2;
  logic [15:0] e_dat1, e_dat2;
  logic        e_wr1, e_wr2, e_ld;

  sym_matrix_load_ctrl #(.DATA_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .diag_valid   (diag_valid),
    .diag_data    (diag_data),
    .diag_ready   (diag_ready),
    .offd_valid   (offd_valid),
    .offd_data    (offd_data),
    .offd_ready   (offd_ready),
    .sel1         (sel1),
    .sel2         (sel2),
    .data_out1    (data_out1),
    .data_out2    (data_out2),
    .wr_en1       (wr_en1),
    .wr_en2       (wr_en2),
    .busy         (busy),
    .matrix_valid (matrix_valid),
    .load_done    (load_done),
    .consume      (consume)
  );

  always #5 clk = ~clk;

  wire [43:0] act_vec = {diag_ready, offd_ready, sel1, sel2, data_out1, data_out2,
                         wr_en1, wr_en2, busy, matrix_valid, load_done};

  function automatic logic [43:0] exp_vec();
    return {(m_state == 1) && (m_dc < 4), (m_state == 1) && (m_oc < 6), e_sel1, e_sel2,
            e_dat1, e_dat2, e_wr1, e_wr2, m_state == 1, m_state == 2, e_ld};
  endfunction

  task automatic model_reset();
    m_state = 0; m_dc = 0; m_oc = 0;
    e_sel1 = '0; e_sel2 = '0; e_dat1 = '0; e_dat2 = '0;
    e_wr1 = 1'b0; e_wr2 = 1'b0; e_ld = 1'b0;
  endtask

  // Advance one clock and update the model from the inputs present at that edge.
  task automatic step();
    logic h1, h2;
    h1 = (m_state == 1) && diag_valid && (m_dc < 4) && !abort;
    h2 = (m_state == 1) && offd_valid && (m_oc < 6) && !abort;
    @(posedge clk);
    e_wr1 = h1; e_wr2 = h2; e_ld = 1'b0;
    if (h1) begin e_sel1 = 2'(m_dc); e_dat1 = diag_data; m_dc++; end
    if (h2) begin e_sel2 = 3'(m_oc); e_dat2 = offd_data; m_oc++; end
    case (m_state)
      0: if (start) begin m_state = 1; m_dc = 0; m_oc = 0; end
      1: if (abort) begin m_state = 0; m_dc = 0; m_oc = 0; end
         else if (m_dc == 4 && m_oc == 6) begin m_state = 2; e_ld = 1'b1; end
      default: if (consume) m_state = 0;
    endcase
    #1;
  endtask

  task automatic drive_next_data();
    if (m_dc < 4) diag_data = 16'h0011 * 16'(m_dc + 1);
    if (m_oc < 6) offd_data = 16'h0101 * 16'(m_oc + 1);
  endtask

  task automatic load_matrix();
    start = 1'b1; step(); start = 1'b0;
    diag_valid = 1'b1; offd_valid = 1'b1;
    for (int i = 0; i < 50 && m_state != 2; i++) begin
      drive_next_data();
      step();
    end
    diag_valid = 1'b0; offd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; model_reset();
    #12;
    n_checks++;
    if (act_vec !== 44'h0) begin
      $display("FAIL reset_outputs actual=%h required=%h", act_vec, 44'h0); n_fail++;
    end
    rst_n = 1'b1;
    diag_valid = 1'b1; offd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (act_vec !== exp_vec()) begin
        $display("FAIL reset_idle actual=%h required=%h", act_vec, exp_vec()); n_fail++;
      end
    end
    diag_valid = 1'b0; offd_valid = 1'b0;
  endtask

  task automatic test_full_load();
    int cyc, ld_at, nw1, nw2;
    logic [1:0]  s1[4]; logic [15:0] d1[4];
    logic [2:0]  s2[6]; logic [15:0] d2[6];
    cyc = 1; ld_at = -1; nw1 = 0; nw2 = 0;
    start = 1'b1; step(); start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || diag_ready !== 1'b1 || offd_ready !== 1'b1) begin
      $display("FAIL full_load_enter busy=%b dr=%b or=%b required=111", busy, diag_ready, offd_ready); n_fail++;
    end
    diag_valid = 1'b1; offd_valid = 1'b1;
    while (ld_at < 0 && cyc < 20) begin
      drive_next_data();
      step(); cyc++;
      n_checks++;
      if (act_vec !== exp_vec()) begin
        $display("FAIL full_load_cycle%0d actual=%h required=%h", cyc, act_vec, exp_vec()); n_fail++;
      end
      if (wr_en1 && nw1 < 4) begin s1[nw1] = sel1; d1[nw1] = data_out1; nw1++; end
      if (wr_en2 && nw2 < 6) begin s2[nw2] = sel2; d2[nw2] = data_out2; nw2++; end
      if (load_done) ld_at = cyc;
    end
    diag_valid = 1'b0; offd_valid = 1'b0;
    n_checks++;
    if (ld_at != 7) begin
      $display("FAIL full_load_done_cycle actual=%0d required=7", ld_at); n_fail++;
    end
    n_checks++;
    if (nw1 != 4 || nw2 != 6) begin
      $display("FAIL full_load_writes actual=%0d/%0d required=4/6", nw1, nw2); n_fail++;
    end
    for (int i = 0; i < nw1; i++) begin
      n_checks++;
      if (s1[i] !== 2'(i) || d1[i] !== 16'h0011 * 16'(i + 1)) begin
        $display("FAIL full_load_diag%0d actual=%0d/%h required=%0d/%h", i, s1[i], d1[i], i, 16'h0011 * 16'(i + 1)); n_fail++;
      end
    end
    for (int i = 0; i < nw2; i++) begin
      n_checks++;
      if (s2[i] !== 3'(i) || d2[i] !== 16'h0101 * 16'(i + 1)) begin
        $display("FAIL full_load_offd%0d actual=%0d/%h required=%0d/%h", i, s2[i], d2[i], i, 16'h0101 * 16'(i + 1)); n_fail++;
      end
    end
    step();
    n_checks++;
    if (matrix_valid !== 1'b1 || load_done !== 1'b0) begin
      $display("FAIL full_load_hold mv=%b ld=%b required mv=1 ld=0", matrix_valid, load_done); n_fail++;
    end
    consume = 1'b1; step(); consume = 1'b0;
    n_checks++;
    if (act_vec !== exp_vec() || matrix_valid !== 1'b0) begin
      $display("FAIL full_load_consume actual=%h required=%h", act_vec, exp_vec()); n_fail++;
    end
  endtask

  task automatic test_same_cycle_final();
    int n_ld, c1, c2;
    n_ld = 0; c1 = -1; c2 = -1;
    start = 1'b1; step(); start = 1'b0;
    offd_valid = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      diag_valid = (i >= 3);
      drive_next_data();
      step();
      n_checks++;
      if (act_vec !== exp_vec()) begin
        $display("FAIL same_cycle_step%0d actual=%h required=%h", i, act_vec, exp_vec()); n_fail++;
      end
      if (load_done) n_ld++;
      if (wr_en1 && sel1 == 2'd3) c1 = i;
      if (wr_en2 && sel2 == 3'd5) c2 = i;
    end
    diag_valid = 1'b0; offd_valid = 1'b0;
    n_checks++;
    if (n_ld != 1 || c1 != c2 || c1 < 0) begin
      $display("FAIL same_cycle_single_done pulses=%0d last_d=%0d last_o=%0d required 1 pulse, equal", n_ld, c1, c2); n_fail++;
    end
    consume = 1'b1; step(); consume = 1'b0;
  endtask

  task automatic test_abort();
    start = 1'b1; step(); start = 1'b0;
    diag_valid = 1'b1; offd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      diag_valid = (i < 2);
      drive_next_data();
      step();
    end
    n_checks++;
    if (act_vec !== exp_vec() || sel1 !== 2'd1 || sel2 !== 3'd2) begin
      $display("FAIL abort_progress actual=%h required=%h", act_vec, exp_vec()); n_fail++;
    end
    abort = 1'b1; diag_valid = 1'b1; offd_valid = 1'b1; drive_next_data();
    step(); abort = 1'b0;
    n_checks++;
    if (wr_en1 !== 1'b0 || wr_en2 !== 1'b0 || busy !== 1'b0 || diag_ready !== 1'b0) begin
      $display("FAIL abort_drop wr=%b%b busy=%b dr=%b required 0000", wr_en1, wr_en2, busy, diag_ready); n_fail++;
    end
    n_checks++;
    if (act_vec !== exp_vec()) begin
      $display("FAIL abort_state actual=%h required=%h", act_vec, exp_vec()); n_fail++;
    end
    start = 1'b1; step(); start = 1'b0;
    drive_next_data(); step();
    n_checks++;
    if (wr_en1 !== 1'b1 || wr_en2 !== 1'b1 || sel1 !== 2'd0 || sel2 !== 3'd0 ||
        data_out1 !== 16'h0011 || data_out2 !== 16'h0101) begin
      $display("FAIL abort_restart wr=%b%b sel=%0d/%0d data=%h/%h required 11 0/0 0011/0101",
               wr_en1, wr_en2, sel1, sel2, data_out1, data_out2); n_fail++;
    end
    for (int i = 0; i < 10 && m_state != 2; i++) begin drive_next_data(); step(); end
    diag_valid = 1'b0; offd_valid = 1'b0;
    consume = 1'b1; step(); consume = 1'b0;
  endtask

  task automatic test_full_hold();
    load_matrix();
    n_checks++;
    if (matrix_valid !== 1'b1) begin
      $display("FAIL hold_reach_full mv=%b required=1", matrix_valid); n_fail++;
    end
    start = 1'b1; abort = 1'b1; diag_valid = 1'b1; offd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      diag_data = 16'($urandom); offd_data = 16'($urandom);
      step();
      n_checks++;
      if (diag_ready !== 1'b0 || offd_ready !== 1'b0 || wr_en1 !== 1'b0 || wr_en2 !== 1'b0 ||
          act_vec !== exp_vec()) begin
        $display("FAIL hold_in_full actual=%h required=%h", act_vec, exp_vec()); n_fail++;
      end
    end
    start = 1'b0; abort = 1'b0; diag_valid = 1'b0; offd_valid = 1'b0;
    consume = 1'b1; step(); consume = 1'b0;
    n_checks++;
    if (matrix_valid !== 1'b0 || act_vec !== exp_vec()) begin
      $display("FAIL hold_consume actual=%h required=%h", act_vec, exp_vec()); n_fail++;
    end
  endtask

  task automatic test_async_reset();
    start = 1'b1; step(); start = 1'b0;
    diag_valid = 1'b1; offd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin drive_next_data(); step(); end
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (act_vec !== 44'h0) begin
      $display("FAIL async_reset_outputs actual=%h required=%h", act_vec, 44'h0); n_fail++;
    end
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_next_data();
      step();
      n_checks++;
      if (act_vec !== exp_vec()) begin
        $display("FAIL async_reset_idle actual=%h required=%h", act_vec, exp_vec()); n_fail++;
      end
    end
    diag_valid = 1'b0; offd_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int m = 0; m < 4; m++) begin
      int c1, c2, cyc; bit done;
      c1 = 0; c2 = 0; cyc = 0; done = 0;
      start = 1'b1; step(); start = 1'b0;
      diag_data = 16'($urandom); offd_data = 16'($urandom);
      while (!done && cyc < 200) begin
        diag_valid = ($urandom_range(0, 2) != 0);
        offd_valid = ($urandom_range(0, 2) != 0);
        step(); cyc++;
        n_checks++;
        if (act_vec !== exp_vec()) begin
          $display("FAIL random_m%0d_c%0d actual=%h required=%h", m, cyc, act_vec, exp_vec()); n_fail++;
        end
        if (wr_en1) begin
          n_checks++;
          if (sel1 !== 2'(c1)) begin
            $display("FAIL random_sel1_order actual=%0d required=%0d", sel1, c1); n_fail++;
          end
          c1++; diag_data = 16'($urandom);
        end
        if (wr_en2) begin
          n_checks++;
          if (sel2 > 3'd5 || sel2 !== 3'(c2)) begin
            $display("FAIL random_sel2_order actual=%0d required=%0d", sel2, c2); n_fail++;
          end
          c2++; offd_data = 16'($urandom);
        end
        if (load_done) done = 1;
      end
      diag_valid = 1'b0; offd_valid = 1'b0;
      n_checks++;
      if (!done || c1 != 4 || c2 != 6) begin
        $display("FAIL random_count_m%0d done=%0d writes=%0d/%0d required 1 4/6", m, done, c1, c2); n_fail++;
      end
      if (!done) begin
        rst_n = 1'b0; #2 rst_n = 1'b1; model_reset();
      end else begin
        for (int w = 0; w < $urandom_range(0, 3); w++) step();
        consume = 1'b1; step(); consume = 1'b0;
        n_checks++;
        if (act_vec !== exp_vec()) begin
          $display("FAIL random_consume_m%0d actual=%h required=%h", m, act_vec, exp_vec()); n_fail++;
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_full_load();
    test_same_cycle_final();
    test_abort();
    test_full_hold();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
